multicyc_exec_unit: RTL and testbench
=====================================

# multicyc_exec_unit

Parametrised multi-cycle arithmetic unit for the execute stage: performs MIPS MULT/MULTU/MUL, DIV/DIVU and MADD/MADDU/MSUB/MSUBU over several cycles and returns the 64-bit HI/LO result and the 32-bit MUL result. These are the values the execute logic consumes as its multi-cycle HI/LO and register results. Multiplier pipeline depth and divider radix are configurable. A pipeline flush cancels the operation in flight.

## Interface
- MUL_STAGES, 2: multiplier latency in cycles, 1..4.
- DIV_BITS_PER_CYCLE, 1: quotient bits resolved per divider iteration, one of {1, 2, 4}.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  cancel the operation in flight; no done is produced.
- start  in  1  request an operation; accepted only when busy=0.
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MUL; 9..15 illegal.
- reg1  in  32  rs operand (dividend / multiplicand).
- reg2  in  32  rt operand (divisor / multiplier).
- hilo_i  in  64  current {HI,LO}; sampled at accept.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: result valid.
- hilo_o  out  64  {HI,LO} result; held until the next accept.
- reg_o  out  32  low 32 bits of the product for MUL, 0 for all other ops; held.

## Operation
- Reset: FSM=IDLE, busy=0, done=0, hilo_o=0, reg_o=0.
- FSM states: IDLE, MUL, DIV_PRE, DIV_ITER, DIV_POST, DONE.
- Accept: start=1 & busy=0 & flush=0. The unit latches op, reg1, reg2 and hilo_i, and sets busy=1.
- Multiply ops go to MUL. Signed ops (0, 4, 6, 8) form a 64-bit two's-complement product; unsigned ops form a zero-extended product.
- MADD/MADDU: hilo_o = hilo_i + product, mod 2^64.
- MSUB/MSUBU: hilo_o = hilo_i - product, mod 2^64.
- MUL: reg_o = product[31:0]; hilo_o = hilo_i, so HI/LO is unchanged.
- Divide ops with reg2≠0: DIV_PRE → DIV_ITER → DIV_POST.
  - DIV_PRE takes operand magnitudes (signed op) or the raw operands (unsigned op).
  - DIV_ITER is restoring division, 32/DIV_BITS_PER_CYCLE iterations, driven by a down-counter.
  - DIV_POST negates the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Result: hilo_o = {remainder, quotient}.
- Divide by zero (reg2=0): go directly to DONE. hilo_o = {reg1, 32'hFFFF_FFFF}.
- Signed 0x8000_0000 / 0xFFFF_FFFF: hilo_o = {0, 0x8000_0000}; no trap is raised.
- Illegal op: go directly to DONE. hilo_o = hilo_i, reg_o = 0.
- DONE: done=1 and busy=0 for one cycle. The outputs register at the same edge. The FSM returns to IDLE, or accepts a new start in that same cycle.
- flush=1 in any state forces IDLE at the next edge with no done. hilo_o and reg_o keep their previous values. flush and start together: flush wins, start is ignored.
- start while busy=1 is ignored; the latched operands are not disturbed.

## Timing
- Let accept be cycle 0. done is asserted in cycle:
  - MUL_STAGES for multiply ops, including MUL, MADD and MSUB.
  - 32/DIV_BITS_PER_CYCLE + 2 for divide, e.g. 34 at radix 1 or 10 at radix 4.
  - 1 for divide by zero and for illegal ops.
- busy is 1 from cycle 1 up to and excluding the done cycle.
- Back-to-back throughput: a new accept is allowed in the done cycle.
- Asynchronous rst mid-operation clears all state immediately; no done follows.

## Configuration
- MULTICYC_MADD_EN defined: ops 4..7 accumulate into hilo_i as described above.
- Undefined: ops 4..7 are treated as illegal. They complete in 1 cycle with hilo_o = hilo_i, and the accumulate adder is removed.

## Test plan
- MULT, reg1=0xFFFF_FFFD (-3), reg2=5, MUL_STAGES=2 → done in cycle 2, hilo_o=0xFFFF_FFFF_FFFF_FFF1, reg_o=0.
- DIV, reg1=0xFFFF_FFF9 (-7), reg2=2, DIV_BITS_PER_CYCLE=2 → done in cycle 18, hilo_o={0xFFFF_FFFF, 0xFFFF_FFFD}.
- DIVU, reg1=0x1234, reg2=0 → done in cycle 1, hilo_o={0x0000_1234, 0xFFFF_FFFF}.
- With MULTICYC_MADD_EN: MSUBU, hilo_i=0x10, reg1=3, reg2=7 → hilo_o=0xFFFF_FFFF_FFFF_FFFB.
  - Without the macro, the same stimulus gives hilo_o=0x10 in cycle 1.
- DIV accepted, flush in cycle 5 → busy=0 in cycle 6, no done pulse, hilo_o unchanged.
  - A start held high during busy causes no re-accept.
- MUL 0x10000 × 0x10000 followed by a start for MULTU 2×3 in the done cycle:
  - MUL result: reg_o=0, hilo_o=hilo_i.
  - MULTU is accepted back-to-back; done MUL_STAGES later with hilo_o=6.

Source files
------------

// File: rtl/multicyc_exec_unit.sv
// rtl/multicyc_exec_unit.sv - multi-cycle MULT/DIV/MADD execute unit for HI/LO and MUL results
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MULTICYC_MADD_EN.
module multicyc_exec_unit #(
    parameter int MUL_STAGES         = 2,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic [63:0] hilo_i,
    output logic        busy,
    output logic        done,
    output logic [63:0] hilo_o,
    output logic [31:0] reg_o
);

    localparam int         DIV_ITERS    = 32 / DIV_BITS_PER_CYCLE;
    localparam logic [5:0] MUL_CNT_INIT = 6'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
    localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_ITERS - 2);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV_PRE, S_DIV_ITER, S_DIV_POST, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [63:0] h_q, h_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [63:0] hilo_q, hilo_d;
    logic [31:0] rego_q, rego_d;

    logic        accept;
    logic        op_is_mul;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [63:0] m_h;
    logic        m_signed;
    logic [63:0] ext_a, ext_b, product, mul_hilo;
    logic [31:0] mul_reg;

    logic        div_signed;
    logic [31:0] mag_a, mag_b;
    logic [31:0] it_rem, it_quo, it_dvs;
    logic [32:0] trial;
    logic        neg_q, neg_r;

    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done   = (state_q == S_DONE);
    assign hilo_o = hilo_q;
    assign reg_o  = rego_q;
    assign accept = start && !busy && !flush;

    always_comb begin
`ifdef MULTICYC_MADD_EN
        op_is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL) ||
                    (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
        op_is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL);
`endif
    end

    // A single-stage multiplier works straight from the ports at accept.
    always_comb begin
        m_op     = (state_q == S_MUL) ? op_q : op;
        m_a      = (state_q == S_MUL) ? a_q : reg1;
        m_b      = (state_q == S_MUL) ? b_q : reg2;
        m_h      = (state_q == S_MUL) ? h_q : hilo_i;
        m_signed = (m_op == OP_MULT) || (m_op == OP_MADD) || (m_op == OP_MSUB) || (m_op == OP_MUL);
        ext_a    = m_signed ? {{32{m_a[31]}}, m_a} : {32'd0, m_a};
        ext_b    = m_signed ? {{32{m_b[31]}}, m_b} : {32'd0, m_b};
        product  = ext_a * ext_b;
        mul_hilo = product;
        mul_reg  = 32'd0;
        case (m_op)
`ifdef MULTICYC_MADD_EN
            OP_MADD, OP_MADDU: mul_hilo = m_h + product;
            OP_MSUB, OP_MSUBU: mul_hilo = m_h - product;
`endif
            OP_MUL: begin
                mul_hilo = m_h;
                mul_reg  = product[31:0];
            end
            default: ;
        endcase
    end

    // Restoring division step; DIV_PRE feeds the first step from the fresh magnitudes.
    always_comb begin
        div_signed = (op_q == OP_DIV);
        mag_a      = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
        mag_b      = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
        neg_q      = div_signed && (a_q[31] ^ b_q[31]);
        neg_r      = div_signed && a_q[31];
        it_rem     = (state_q == S_DIV_PRE) ? 32'd0 : rem_q;
        it_quo     = (state_q == S_DIV_PRE) ? mag_a : quo_q;
        it_dvs     = (state_q == S_DIV_PRE) ? mag_b : dvs_q;
        trial      = 33'd0;
        for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
            trial  = {it_rem, it_quo[31]};
            it_quo = {it_quo[30:0], 1'b0};
            if (trial >= {1'b0, it_dvs}) begin
                trial     = trial - {1'b0, it_dvs};
                it_quo[0] = 1'b1;
            end
            it_rem = trial[31:0];
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hilo_d  = hilo_q;
        rego_d  = rego_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d = op;
                    a_d  = reg1;
                    b_d  = reg2;
                    h_d  = hilo_i;
                    if (op_is_mul) begin
                        if (MUL_STAGES == 1) begin
                            hilo_d  = mul_hilo;
                            rego_d  = mul_reg;
                            state_d = S_DONE;
                        end else begin
                            cnt_d   = MUL_CNT_INIT;
                            state_d = S_MUL;
                        end
                    end else if ((op == OP_DIV) || (op == OP_DIVU)) begin
                        if (reg2 == 32'd0) begin
                            hilo_d  = {reg1, 32'hFFFF_FFFF};
                            rego_d  = 32'd0;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DIV_PRE;
                        end
                    end else begin
                        hilo_d  = hilo_i;
                        rego_d  = 32'd0;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == 6'd0) begin
                    hilo_d  = mul_hilo;
                    rego_d  = mul_reg;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_DIV_PRE: begin
                rem_d   = it_rem;
                quo_d   = it_quo;
                dvs_d   = mag_b;
                cnt_d   = DIV_CNT_INIT;
                state_d = S_DIV_ITER;
            end
            S_DIV_ITER: begin
                rem_d = it_rem;
                quo_d = it_quo;
                if (cnt_q == 6'd0) begin
                    state_d = S_DIV_POST;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_DIV_POST: begin
                hilo_d  = {neg_r ? (32'd0 - rem_q) : rem_q, neg_q ? (32'd0 - quo_q) : quo_q};
                rego_d  = 32'd0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            hilo_d  = hilo_q;
            rego_d  = rego_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            h_q     <= 64'd0;
            cnt_q   <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            hilo_q  <= 64'd0;
            rego_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hilo_q  <= hilo_d;
            rego_q  <= rego_d;
        end
    end

endmodule

// File: tb/tb_multicyc_exec_unit.sv
// tb/tb_multicyc_exec_unit.sv - directed scoreboard bench for multicyc_exec_unit (MUL_STAGES=2, radix 2)
module tb_multicyc_exec_unit;

    logic        clk = 1'b0;
    logic        rst, flush, start;
    logic [3:0]  op;
    logic [31:0] reg1, reg2;
    logic [63:0] hilo_i;
    logic        busy, done;
    logic [63:0] hilo_o;
    logic [31:0] reg_o;

    typedef struct {
        string       tag;
        logic [63:0] hilo;
        logic [31:0] rg;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    multicyc_exec_unit #(.MUL_STAGES(2), .DIV_BITS_PER_CYCLE(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .reg1(reg1), .reg2(reg2), .hilo_i(hilo_i),
        .busy(busy), .done(done), .hilo_o(hilo_o), .reg_o(reg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] h,
                          input logic [63:0] e_hilo, input logic [31:0] e_reg, input int e_lat);
        exp_t e;
        e.tag = tag; e.hilo = e_hilo; e.rg = e_reg; e.lat = e_lat;
        sb.push_back(e);
        op = o; reg1 = a; reg2 = b; hilo_i = h; start = 1'b1;
    endtask

    // Returns in the done cycle, so the next launch is accepted back-to-back.
    task automatic wait_result(input bit hold);
        exp_t e;
        int   cyc;
        e = sb.pop_front();
        @(posedge clk); #1;
        cyc = 1;
        if (hold) begin
            op = 4'd1; reg1 = 32'hDEAD_BEEF; reg2 = 32'h0000_0005; hilo_i = 64'h1234;
        end
        if (e.lat > 1) chk({e.tag, " busy"}, 64'(busy), 64'd1);
        while (!done && cyc < 100) begin
            start = hold && (cyc < e.lat);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({e.tag, " done"}, 64'(done), 64'd1);
        chk({e.tag, " latency"}, 64'(cyc), 64'(e.lat));
        chk({e.tag, " busy_at_done"}, 64'(busy), 64'd0);
        chk({e.tag, " hilo_o"}, hilo_o, e.hilo);
        chk({e.tag, " reg_o"}, 64'(reg_o), 64'(e.rg));
    endtask

    initial begin
        logic [63:0] prev;
        int          saw_done;
        int          cyc;

        rst = 1'b1; flush = 1'b0; start = 1'b0; op = 4'd0;
        reg1 = 32'd0; reg2 = 32'd0; hilo_i = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hilo_o", hilo_o, 64'd0);
        chk("reset reg_o", 64'(reg_o), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        launch("mult_neg", 4'd0, 32'hFFFF_FFFD, 32'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF1, 32'd0, 2);
        wait_result(1'b0);
        launch("div_neg", 4'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32'd0, 18);
        wait_result(1'b0);
        launch("divu_zero", 4'd3, 32'h0000_1234, 32'd0, 64'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 32'd0, 1);
        wait_result(1'b0);
`ifdef MULTICYC_MADD_EN
        launch("msubu", 4'd7, 32'd3, 32'd7, 64'h10, 64'hFFFF_FFFF_FFFF_FFFB, 32'd0, 2);
`else
        launch("msubu", 4'd7, 32'd3, 32'd7, 64'h10, 64'h10, 32'd0, 1);
`endif
        wait_result(1'b0);
        launch("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, {32'd0, 32'h8000_0000}, 32'd0, 18);
        wait_result(1'b0);
        launch("div_negdvs", 4'd2, 32'd7, 32'hFFFF_FFFE, 64'd0, {32'd1, 32'hFFFF_FFFD}, 32'd0, 18);
        wait_result(1'b0);
        launch("divu_hold", 4'd3, 32'd100, 32'd7, 64'd0, {32'd2, 32'd14}, 32'd0, 18);
        wait_result(1'b1);
        launch("multu_max", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 32'd0, 2);
        wait_result(1'b0);
        launch("mul_neg", 4'd8, 32'hFFFF_FFFE, 32'd3, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 32'hFFFF_FFFA, 2);
        wait_result(1'b0);
        launch("illegal", 4'd9, 32'd1, 32'd2, 64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888, 32'd0, 1);
        wait_result(1'b0);
        launch("mul_b2b", 4'd8, 32'h0001_0000, 32'h0001_0000, 64'hAAAA_BBBB_CCCC_DDDD, 64'hAAAA_BBBB_CCCC_DDDD, 32'd0, 2);
        wait_result(1'b0);
        launch("multu_b2b", 4'd1, 32'd2, 32'd3, 64'd0, 64'd6, 32'd0, 2);
        wait_result(1'b0);

        // Flush in cycle 5 with start held high throughout the busy window.
        prev = hilo_o;
        op = 4'd2; reg1 = 32'd100; reg2 = 32'd3; hilo_i = 64'd0; start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        saw_done = 0;
        op = 4'd1; reg1 = 32'd9; reg2 = 32'd9;
        while (cyc < 5) begin
            if (done) saw_done++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("flush busy_before", 64'(busy), 64'd1);
        start = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy_after", 64'(busy), 64'd0);
        chk("flush hilo_kept", hilo_o, prev);
        repeat (40) begin
            if (done) saw_done++;
            @(posedge clk); #1;
        end
        chk("flush no_done", 64'(saw_done), 64'd0);
        chk("flush hilo_final", hilo_o, prev);

        // Asynchronous reset mid-divide.
        op = 4'd3; reg1 = 32'd50; reg2 = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst hilo_o", hilo_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 0;
        repeat (40) begin
            if (done) saw_done++;
            @(posedge clk); #1;
        end
        chk("arst no_done", 64'(saw_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
